mips_multicycle_ctrl: RTL and testbench
=======================================

Name: mips_multicycle_ctrl

Overview:
Multi-cycle control FSM that sequences the fetch/decode/execute/writeback of one instruction at a time over the existing PC, PC adder, instruction memory, instruction register and ALU datapath. It gates PC update and IR load, decodes the 6-bit opcode into the 4-bit ALU control code, and enables register-file writeback. It sits beside the datapath and replaces free-running clock-edge updates of PC and IR with explicit enables.

Parameters:
CNT_W, 32, width of retired-instruction counter INSTR_COUNT.
FETCH_TIMEOUT, 15, max cycles waiting for MEM_READY in FETCH before trapping (1..255).

Ports:
CLK  in  1  clock; all state changes on posedge.
RESET  in  1  synchronous, active-high reset.
RUN  in  1  1 = allow new fetch; sampled only in IDLE/FETCH entry.
MEM_READY  in  1  instruction memory has valid INSTRUCTION for current PC.
INSTRUCTION  in  32  instruction word from instruction memory.
IR_LOAD  out  1  one-cycle pulse: IR captures INSTRUCTION.
PC_WRITE  out  1  one-cycle pulse: PC takes PC+4.
REG_WRITE  out  1  one-cycle pulse: register file writes rd.
ALU_CTRL  out  4  ALU operation code, valid in EXECUTE and WRITEBACK.
BUSY  out  1  1 whenever state != IDLE and != TRAP.
TRAP  out  1  sticky error flag.
TRAP_CAUSE  out  2  00 none, 01 illegal opcode, 10 fetch timeout.
INSTR_COUNT  out  CNT_W  instructions retired since reset.

Behaviour:
- All outputs registered. RESET (any state, mid-instruction included): state=IDLE, IR_LOAD=PC_WRITE=REG_WRITE=0, ALU_CTRL=0000, BUSY=0, TRAP=0, TRAP_CAUSE=00, INSTR_COUNT=0, timeout counter=0. An in-flight instruction is abandoned: no PC_WRITE/REG_WRITE.
- States: IDLE, FETCH, DECODE, EXECUTE, WRITEBACK, TRAP.
- IDLE: RUN=1 -> FETCH, else stay.
- FETCH: timeout counter increments each cycle MEM_READY=0. MEM_READY=1 -> latch INSTRUCTION internally, IR_LOAD=1 for exactly the next cycle, -> DECODE, counter cleared. Counter reaching FETCH_TIMEOUT with MEM_READY=0 -> TRAP, cause 10. MEM_READY=1 in the same cycle the counter hits the limit: ready wins.
- DECODE: op=INSTR[31:26]. Legal map op->ALU_CTRL: 000000 AND->0000, 000001 OR->0001, 000010 ADD->0010, 000110 SUB->0110, 000111 SLT->0111, 001100 NOR->1100. Legal -> ALU_CTRL loaded, -> EXECUTE. Otherwise -> TRAP, cause 01. ALU_CTRL unchanged.
- EXECUTE: one cycle for ALU settle -> WRITEBACK.
- WRITEBACK: REG_WRITE=1 for one cycle unless rd (INSTR[15:11]) = 0, in which case REG_WRITE stays 0. PC_WRITE=1 for one cycle. INSTR_COUNT += 1 (wraps modulo 2^CNT_W). Next: RUN=1 -> FETCH, RUN=0 -> IDLE.
- Latency: 4 cycles per instruction from FETCH with MEM_READY=1 through the WRITEBACK exit; back-to-back throughput 1 instruction / 4 cycles.
- RUN deassertion mid-instruction does not abort; the instruction completes and the FSM then goes to IDLE.
- TRAP: sticky; outputs held, TRAP=1, BUSY=0, no pulses; exit only via RESET.
- IR_LOAD, PC_WRITE, REG_WRITE never asserted together. PC_WRITE exactly once per retired instruction.

Test Plan:
- RESET mid-EXECUTE of ADD (op 000010, rd=2) -> no PC_WRITE/REG_WRITE; next cycle all outputs at reset values, INSTR_COUNT=0.
- RUN=1, MEM_READY=1 constant, feed ADD, AND, OR, SUB, SLT, NOR words in sequence -> ALU_CTRL 0010, 0000, 0001, 0110, 0111, 1100; PC_WRITE every 4th cycle; INSTR_COUNT=6.
- INSTRUCTION with op 111111 -> TRAP=1, TRAP_CAUSE=01 after DECODE; no PC_WRITE; stays trapped with RUN=1 until RESET.
- MEM_READY held low -> TRAP_CAUSE=10 exactly FETCH_TIMEOUT cycles after FETCH entry; MEM_READY rising on the limit cycle -> no trap, IR_LOAD pulses.
- ADD with rd=0 -> REG_WRITE stays 0, PC_WRITE=1, INSTR_COUNT increments.
- RUN dropped during DECODE -> instruction retires, FSM enters IDLE, BUSY=0; RUN reasserted -> FETCH next cycle.

Source files
------------

// File: rtl/mips_multicycle_ctrl_if.sv
// Handshake bundle between the multi-cycle controller and the PC/IR/ALU datapath.
// The controller takes the master side; the datapath (or a bench) takes the slave side.
interface mips_multicycle_ctrl_if #(
    parameter int CNT_W = 32
);
    logic             run;
    logic             mem_ready;
    logic [31:0]      instruction;
    logic             ir_load;
    logic             pc_write;
    logic             reg_write;
    logic [3:0]       alu_ctrl;
    logic             busy;
    logic             trap;
    logic [1:0]       trap_cause;
    logic [CNT_W-1:0] instr_count;

    modport master (
        input  run, mem_ready, instruction,
        output ir_load, pc_write, reg_write, alu_ctrl, busy, trap, trap_cause, instr_count
    );

    modport slave (
        output run, mem_ready, instruction,
        input  ir_load, pc_write, reg_write, alu_ctrl, busy, trap, trap_cause, instr_count
    );
endinterface

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle FETCH/DECODE/EXECUTE/WRITEBACK sequencer producing registered PC/IR/regfile
// enables and the ALU control code, with a sticky trap for illegal opcodes and fetch timeouts.
module mips_multicycle_ctrl #(
    parameter int CNT_W         = 32,
    parameter int FETCH_TIMEOUT = 15
) (
    input logic                    clk_i,
    input logic                    reset_i,
    mips_multicycle_ctrl_if.master bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXECUTE,
        S_WRITEBACK,
        S_TRAP
    } state_e;

    localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;
    localparam logic [7:0] TMO_LIMIT     = 8'(FETCH_TIMEOUT);

    state_e           state_q;
    logic [5:0]       op_q;
    logic [4:0]       rd_q;
    logic [7:0]       tmo_q;
    logic [7:0]       tmo_d;
    logic             ir_load_q;
    logic             pc_write_q;
    logic             reg_write_q;
    logic [3:0]       alu_ctrl_q;
    logic [3:0]       alu_ctrl_d;
    logic             op_legal;
    logic             busy_q;
    logic             trap_q;
    logic [1:0]       trap_cause_q;
    logic [CNT_W-1:0] instr_count_q;

    assign tmo_d = tmo_q + 8'd1;

    // NOTE: every variable written in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        alu_ctrl_d = 4'b0000;
        op_legal   = 1'b1;
        case (op_q)
            6'b000000: alu_ctrl_d = 4'b0000;
            6'b000001: alu_ctrl_d = 4'b0001;
            6'b000010: alu_ctrl_d = 4'b0010;
            6'b000110: alu_ctrl_d = 4'b0110;
            6'b000111: alu_ctrl_d = 4'b0111;
            6'b001100: alu_ctrl_d = 4'b1100;
            default:   op_legal   = 1'b0;
        endcase
    end

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q       <= S_IDLE;
            op_q          <= '0;
            rd_q          <= '0;
            tmo_q         <= '0;
            ir_load_q     <= 1'b0;
            pc_write_q    <= 1'b0;
            reg_write_q   <= 1'b0;
            alu_ctrl_q    <= 4'b0000;
            busy_q        <= 1'b0;
            trap_q        <= 1'b0;
            trap_cause_q  <= 2'b00;
            instr_count_q <= '0;
        end else begin
            // Enables are single-cycle pulses; only the transitions below raise them.
            ir_load_q   <= 1'b0;
            pc_write_q  <= 1'b0;
            reg_write_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.run) begin
                        state_q <= S_FETCH;
                        busy_q  <= 1'b1;
                        tmo_q   <= '0;
                    end
                end
                S_FETCH: begin
                    if (bus.mem_ready) begin
                        op_q      <= bus.instruction[31:26];
                        rd_q      <= bus.instruction[15:11];
                        ir_load_q <= 1'b1;
                        tmo_q     <= '0;
                        state_q   <= S_DECODE;
                    end else if (tmo_d == TMO_LIMIT) begin
                        tmo_q        <= tmo_d;
                        state_q      <= S_TRAP;
                        busy_q       <= 1'b0;
                        trap_q       <= 1'b1;
                        trap_cause_q <= CAUSE_TIMEOUT;
                    end else begin
                        tmo_q <= tmo_d;
                    end
                end
                S_DECODE: begin
                    if (op_legal) begin
                        alu_ctrl_q <= alu_ctrl_d;
                        state_q    <= S_EXECUTE;
                    end else begin
                        state_q      <= S_TRAP;
                        busy_q       <= 1'b0;
                        trap_q       <= 1'b1;
                        trap_cause_q <= CAUSE_ILLEGAL;
                    end
                end
                S_EXECUTE: begin
                    // Retirement is committed on entry to WRITEBACK so the pulses and count line up.
                    state_q       <= S_WRITEBACK;
                    pc_write_q    <= 1'b1;
                    reg_write_q   <= (rd_q != 5'd0);
                    instr_count_q <= instr_count_q + CNT_W'(1);
                end
                S_WRITEBACK: begin
                    if (bus.run) begin
                        state_q <= S_FETCH;
                        tmo_q   <= '0;
                    end else begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                S_TRAP: begin
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ir_load     = ir_load_q;
    assign bus.pc_write    = pc_write_q;
    assign bus.reg_write   = reg_write_q;
    assign bus.alu_ctrl    = alu_ctrl_q;
    assign bus.busy        = busy_q;
    assign bus.trap        = trap_q;
    assign bus.trap_cause  = trap_cause_q;
    assign bus.instr_count = instr_count_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed bench for mips_multicycle_ctrl: a scoreboard of expected retirements is filled as
// instructions are driven and drained by a monitor on every PC_WRITE pulse.
module tb_mips_multicycle_ctrl;
    localparam int CNT_W         = 32;
    localparam int FETCH_TIMEOUT = 15;

    typedef struct {
        logic [3:0]       alu;
        logic             regw;
        logic [CNT_W-1:0] count;
        bit               b2b;
    } exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cycle   = 0;
    int   last_pc_cycle = -100;
    exp_t sb[$];
    exp_t mon_e;
    logic [CNT_W-1:0] model_count = '0;

    logic [5:0] ops  [6] = '{6'b000010, 6'b000000, 6'b000001, 6'b000110, 6'b000111, 6'b001100};
    logic [3:0] alus [6] = '{4'b0010, 4'b0000, 4'b0001, 4'b0110, 4'b0111, 4'b1100};

    mips_multicycle_ctrl_if #(.CNT_W(CNT_W)) bus ();

    mips_multicycle_ctrl #(
        .CNT_W        (CNT_W),
        .FETCH_TIMEOUT(FETCH_TIMEOUT)
    ) dut (
        .clk_i  (clk),
        .reset_i(reset),
        .bus    (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycle++;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rd);
        return {op, 5'd1, 5'd2, rd, 11'd0};
    endfunction

    task automatic push(input logic [3:0] alu, input logic regw, input bit b2b);
        exp_t e;
        model_count++;
        e.alu   = alu;
        e.regw  = regw;
        e.count = model_count;
        e.b2b   = b2b;
        sb.push_back(e);
    endtask

    task automatic check_reset(input string tag);
        check({tag, ".ir_load"},     bus.ir_load,     0);
        check({tag, ".pc_write"},    bus.pc_write,    0);
        check({tag, ".reg_write"},   bus.reg_write,   0);
        check({tag, ".alu_ctrl"},    bus.alu_ctrl,    0);
        check({tag, ".busy"},        bus.busy,        0);
        check({tag, ".trap"},        bus.trap,        0);
        check({tag, ".trap_cause"},  bus.trap_cause,  0);
        check({tag, ".instr_count"}, bus.instr_count, 0);
    endtask

    // Retirement monitor: every PC_WRITE must match the oldest pending scoreboard entry.
    always @(negedge clk) begin
        if (bus.ir_load)
            check("ir_load_alone", {bus.pc_write, bus.reg_write}, 0);
        if (bus.reg_write)
            check("reg_write_in_wb", bus.pc_write, 1);
        if (bus.pc_write) begin
            check("pc_write_expected", sb.size() > 0, 1);
            if (sb.size() > 0) begin
                mon_e = sb.pop_front();
                check("wb_alu_ctrl",    bus.alu_ctrl,    mon_e.alu);
                check("wb_reg_write",   bus.reg_write,   mon_e.regw);
                check("wb_instr_count", bus.instr_count, mon_e.count);
                check("wb_busy",        bus.busy,        1);
                if (mon_e.b2b)
                    check("pc_write_period", cycle - last_pc_cycle, 4);
            end
            last_pc_cycle = cycle;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected $finish");
        $fatal(1);
    end

    initial begin
        bus.run         = 1'b0;
        bus.mem_ready   = 1'b0;
        bus.instruction = '0;
        cyc(2);
        check_reset("por");
        reset = 1'b0;

        // Reset in the middle of an ADD: nothing retires.
        bus.run         = 1'b1;
        bus.mem_ready   = 1'b1;
        bus.instruction = mk(6'b000010, 5'd2);
        cyc(1);
        check("rst_case.busy_fetch", bus.busy, 1);
        cyc(1);
        check("rst_case.ir_load", bus.ir_load, 1);
        cyc(1);
        check("rst_case.alu_exec", bus.alu_ctrl, 4'b0010);
        check("rst_case.ir_load_drop", bus.ir_load, 0);
        reset   = 1'b1;
        bus.run = 1'b0;
        cyc(1);
        check_reset("rst_mid_exec");
        reset = 1'b0;
        cyc(1);
        check_reset("rst_after");

        // Back-to-back ADD, AND, OR, SUB, SLT, NOR.
        bus.run         = 1'b1;
        bus.mem_ready   = 1'b1;
        bus.instruction = mk(ops[0], 5'd1);
        cyc(1);
        for (int i = 0; i < 6; i++) begin
            bus.instruction = mk(ops[i], 5'(i + 1));
            push(alus[i], 1'b1, i > 0);
            cyc(1);
            check("b2b.ir_load", bus.ir_load, 1);
            cyc(1);
            check("b2b.alu_exec", bus.alu_ctrl, alus[i]);
            cyc(1);
            if (i == 5) bus.run = 1'b0;
            cyc(1);
        end
        check("b2b.idle_busy", bus.busy, 0);
        check("b2b.count", bus.instr_count, 6);

        // Illegal opcode traps after DECODE and stays trapped.
        bus.run         = 1'b1;
        bus.instruction = mk(6'b111111, 5'd3);
        cyc(3);
        check("illegal.trap",  bus.trap,       1);
        check("illegal.cause", bus.trap_cause, 2'b01);
        check("illegal.busy",  bus.busy,       0);
        check("illegal.alu_held", bus.alu_ctrl, 4'b1100);
        cyc(5);
        check("illegal.sticky_trap",  bus.trap,        1);
        check("illegal.sticky_cause", bus.trap_cause,  2'b01);
        check("illegal.count_held",   bus.instr_count, 6);
        reset = 1'b1;
        cyc(1);
        reset       = 1'b0;
        model_count = '0;
        check_reset("rst_from_trap");

        // Fetch timeout with MEM_READY held low.
        bus.mem_ready = 1'b0;
        bus.run       = 1'b1;
        cyc(1);
        cyc(FETCH_TIMEOUT - 1);
        check("tmo.not_yet", bus.trap, 0);
        check("tmo.busy",    bus.busy, 1);
        cyc(1);
        check("tmo.trap",  bus.trap,       1);
        check("tmo.cause", bus.trap_cause, 2'b10);
        check("tmo.busy_drop", bus.busy,   0);
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
        check_reset("rst_from_tmo");

        // MEM_READY arriving on the limit cycle wins over the timeout.
        cyc(1);
        cyc(FETCH_TIMEOUT - 1);
        bus.mem_ready   = 1'b1;
        bus.instruction = mk(6'b000010, 5'd3);
        push(4'b0010, 1'b1, 1'b0);
        cyc(1);
        check("limit.ir_load", bus.ir_load, 1);
        check("limit.no_trap", bus.trap,    0);
        cyc(2);
        bus.run = 1'b0;
        cyc(1);
        check("limit.idle", bus.busy, 0);

        // ADD with rd=0, RUN dropped during DECODE.
        bus.run         = 1'b1;
        bus.instruction = mk(6'b000010, 5'd0);
        push(4'b0010, 1'b0, 1'b0);
        cyc(2);
        check("rd0.decode_ir_load", bus.ir_load, 1);
        bus.run = 1'b0;
        cyc(2);
        cyc(1);
        check("rd0.idle_busy", bus.busy, 0);
        check("rd0.count", bus.instr_count, 2);
        bus.run         = 1'b1;
        bus.instruction = mk(6'b000001, 5'd5);
        push(4'b0001, 1'b1, 1'b0);
        cyc(1);
        check("rerun.busy", bus.busy, 1);
        cyc(3);
        bus.run = 1'b0;
        cyc(1);
        check("rerun.idle", bus.busy, 0);
        check("rerun.count", bus.instr_count, 3);

        cyc(2);
        check("sb_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
